// File: rtl/ivl_uvm_vr_monitor.sv
// ivl_uvm_vr_monitor
// Watches one valid/ready channel, counts completed transfers and turns
// protocol violations into timestamped entries in a small message queue.
// A reporter drains the queue through a valid/ready port.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mon_valid/ready/data  monitored channel
//   msg_valid/ready       message queue output handshake (head entry)
//   msg_sev               1=WARNING, 2=ERROR
//   msg_id                1=VALID_DROP, 2=DATA_UNSTABLE, 3=STALL_TIMEOUT
//   msg_time              cycle count at the detection edge
//   msg_data              data associated with the event
//   xfer_cnt              completed transfers (wraps)
//   err_cnt, warn_cnt     detected ERROR/WARNING events (saturate)
//   drop_cnt              entries lost to a full queue (saturates)
module ivl_uvm_vr_monitor #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_STALL = 16,
  parameter int unsigned MSG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mon_valid,
  input  logic              mon_ready,
  input  logic [DATA_W-1:0] mon_data,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [1:0]        msg_sev,
  output logic [1:0]        msg_id,
  output logic [31:0]       msg_time,
  output logic [DATA_W-1:0] msg_data,
  output logic [31:0]       xfer_cnt,
  output logic [15:0]       err_cnt,
  output logic [15:0]       warn_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned AW          = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam logic [15:0] STALL_LIMIT = 16'(MAX_STALL);
  localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(MSG_DEPTH);

  localparam logic [1:0] SEV_WARNING = 2'd1;
  localparam logic [1:0] SEV_ERROR   = 2'd2;
  localparam logic [1:0] ID_DROP     = 2'd1;
  localparam logic [1:0] ID_UNSTABLE = 2'd2;
  localparam logic [1:0] ID_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    STALLED
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   cap_data, cap_nxt;
  logic [15:0]         stall_cnt, stall_nxt;
  logic [31:0]         cyc_cnt;

  logic                xfer_inc;
  logic                drop_ev, unst_ev, tmo_ev;
  logic                push, pop, full, push_ok, push_lost;
  logic [1:0]          ent_sev, ent_id;
  logic [DATA_W-1:0]   ent_data;

  logic [1:0]          mem_sev  [MSG_DEPTH];
  logic [1:0]          mem_id   [MSG_DEPTH];
  logic [31:0]         mem_time [MSG_DEPTH];
  logic [DATA_W-1:0]   mem_data [MSG_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;

  // Protocol checker: next state and the events detected at this edge.
  always_comb begin
    state_nxt = state;
    cap_nxt   = cap_data;
    stall_nxt = stall_cnt;
    xfer_inc  = 1'b0;
    drop_ev   = 1'b0;
    unst_ev   = 1'b0;
    tmo_ev    = 1'b0;
    case (state)
      IDLE: begin
        if (mon_valid) begin
          if (mon_ready) begin
            xfer_inc = 1'b1;
          end else begin
            cap_nxt   = mon_data;
            stall_nxt = 16'd1;
            state_nxt = PENDING;
          end
        end
      end
      PENDING, STALLED: begin
        if (!mon_valid) begin
          drop_ev   = 1'b1;
          state_nxt = IDLE;
        end else begin
          // A data change is reported and the transfer still completes
          // on the same edge if ready is high.
          if (mon_data != cap_data) begin
            unst_ev = 1'b1;
            cap_nxt = mon_data;
          end
          if (mon_ready) begin
            xfer_inc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            stall_nxt = stall_cnt + 16'd1;
            if ((state == PENDING) && (stall_nxt == STALL_LIMIT)) begin
              tmo_ev    = 1'b1;
              state_nxt = STALLED;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the highest-priority event of an edge is queued; the others
  // still reach the counters.
  always_comb begin
    push = drop_ev | unst_ev | tmo_ev;
    if (drop_ev) begin
      ent_sev  = SEV_ERROR;
      ent_id   = ID_DROP;
      ent_data = cap_data;
    end else if (unst_ev) begin
      ent_sev  = SEV_ERROR;
      ent_id   = ID_UNSTABLE;
      ent_data = mon_data;
    end else begin
      ent_sev  = SEV_WARNING;
      ent_id   = ID_TIMEOUT;
      ent_data = cap_data;
    end
  end

  assign msg_valid = (count != '0);
  assign msg_sev   = mem_sev[rd_ptr];
  assign msg_id    = mem_id[rd_ptr];
  assign msg_time  = mem_time[rd_ptr];
  assign msg_data  = mem_data[rd_ptr];

  assign pop       = msg_valid & msg_ready;
  assign full      = (count == DEPTH_CNT);
  assign push_ok   = push & (~full | pop);
  assign push_lost = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_data  <= '0;
      stall_cnt <= '0;
      cyc_cnt   <= '0;
      xfer_cnt  <= '0;
      err_cnt   <= '0;
      warn_cnt  <= '0;
      drop_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
        mem_sev[i]  <= '0;
        mem_id[i]   <= '0;
        mem_time[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      cap_data  <= cap_nxt;
      stall_cnt <= stall_nxt;
      cyc_cnt   <= cyc_cnt + 32'd1;

      if (xfer_inc)
        xfer_cnt <= xfer_cnt + 32'd1;
      if ((drop_ev | unst_ev) && (err_cnt != '1))
        err_cnt <= err_cnt + 16'd1;
      if (tmo_ev && (warn_cnt != '1))
        warn_cnt <= warn_cnt + 16'd1;
      if (push_lost && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 16'd1;

      if (push_ok) begin
        mem_sev[wr_ptr]  <= ent_sev;
        mem_id[wr_ptr]   <= ent_id;
        mem_time[wr_ptr] <= cyc_cnt;
        mem_data[wr_ptr] <= ent_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ivl_uvm_vr_monitor.sv
// Directed testbench for ivl_uvm_vr_monitor (MAX_STALL=4, MSG_DEPTH=4).
// Edge numbers in the scenarios count from the first edge after reset release.
module tb_ivl_uvm_vr_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mon_valid;
  logic        mon_ready;
  logic [31:0] mon_data;
  logic        msg_valid;
  logic        msg_ready;
  logic [1:0]  msg_sev;
  logic [1:0]  msg_id;
  logic [31:0] msg_time;
  logic [31:0] msg_data;
  logic [31:0] xfer_cnt;
  logic [15:0] err_cnt;
  logic [15:0] warn_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  ivl_uvm_vr_monitor #(
    .DATA_W    (32),
    .MAX_STALL (4),
    .MSG_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon_valid (mon_valid),
    .mon_ready (mon_ready),
    .mon_data  (mon_data),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_sev   (msg_sev),
    .msg_id    (msg_id),
    .msg_time  (msg_time),
    .msg_data  (msg_data),
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt),
    .warn_cnt  (warn_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mon_valid = 1'b0;
    mon_ready = 1'b0;
    mon_data  = '0;
    msg_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mon_valid = 1'b1;
    mon_ready = 1'b1;
    mon_data  = 32'hDEAD_BEEF;
    msg_ready = 1'b1;
    step();
    step();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_msg_valid: got %b expected 0", msg_valid); end
    checks++; if (xfer_cnt !== 32'd0) begin errors++; $display("FAIL reset_xfer_cnt: got %0h expected 0", xfer_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
    checks++; if (warn_cnt !== 16'd0) begin errors++; $display("FAIL reset_warn_cnt: got %0h expected 0", warn_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0h expected 0", drop_cnt); end
    checks++; if ({msg_sev, msg_id} !== 4'd0) begin errors++; $display("FAIL reset_sev_id: got %0h expected 0", {msg_sev, msg_id}); end
    checks++; if (msg_time !== 32'd0) begin errors++; $display("FAIL reset_msg_time: got %0h expected 0", msg_time); end
    checks++; if (msg_data !== 32'd0) begin errors++; $display("FAIL reset_msg_data: got %0h expected 0", msg_data); end
  endtask

  task automatic test_clean();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mon_valid = 1'b1;
      mon_ready = 1'b1;
      mon_data  = 32'(i);
      step();
      checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL clean_msg_valid beat %0d: got %b expected 0", i, msg_valid); end
    end
    mon_valid = 1'b0;
    step();
    checks++; if (xfer_cnt !== 32'd10) begin errors++; $display("FAIL clean_xfer_cnt: got %0d expected 10", xfer_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (warn_cnt !== 16'd0) begin errors++; $display("FAIL clean_warn_cnt: got %0d expected 0", warn_cnt); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    step(); step(); step();           // edges 0..2 idle
    mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'hA5;
    step();                           // edge 3
    mon_valid = 1'b0;
    step();                           // edge 4: drop detected
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL drop_msg_valid: got %b expected 1", msg_valid); end
    checks++; if (msg_sev !== 2'd2) begin errors++; $display("FAIL drop_sev: got %0d expected 2", msg_sev); end
    checks++; if (msg_id !== 2'd1) begin errors++; $display("FAIL drop_id: got %0d expected 1", msg_id); end
    checks++; if (msg_data !== 32'hA5) begin errors++; $display("FAIL drop_data: got %0h expected a5", msg_data); end
    checks++; if (msg_time !== 32'd4) begin errors++; $display("FAIL drop_time: got %0d expected 4", msg_time); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL drop_err_cnt: got %0d expected 1", err_cnt); end
    msg_ready = 1'b1;
    step();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL drop_drained: got %b expected 0", msg_valid); end
  endtask

  task automatic test_data_unstable();
    do_reset();
    mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h11;
    step();                           // edge 0
    mon_data = 32'h22;
    step();                           // edge 1: data change
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL unst_msg_valid: got %b expected 1", msg_valid); end
    checks++; if (msg_sev !== 2'd2) begin errors++; $display("FAIL unst_sev: got %0d expected 2", msg_sev); end
    checks++; if (msg_id !== 2'd2) begin errors++; $display("FAIL unst_id: got %0d expected 2", msg_id); end
    checks++; if (msg_data !== 32'h22) begin errors++; $display("FAIL unst_data: got %0h expected 22", msg_data); end
    checks++; if (msg_time !== 32'd1) begin errors++; $display("FAIL unst_time: got %0d expected 1", msg_time); end
    mon_ready = 1'b1;
    step();                           // edge 2: transfer
    mon_valid = 1'b0; mon_ready = 1'b0;
    checks++; if (xfer_cnt !== 32'd1) begin errors++; $display("FAIL unst_xfer_cnt: got %0d expected 1", xfer_cnt); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL unst_err_cnt: got %0d expected 1", err_cnt); end
    msg_ready = 1'b1;
    step();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL unst_single_entry: got %b expected 0", msg_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h77;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == 2) begin
        checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", msg_valid); end
      end
      if (e == 3) begin
        checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL tmo_msg_valid: got %b expected 1", msg_valid); end
        checks++; if (msg_sev !== 2'd1) begin errors++; $display("FAIL tmo_sev: got %0d expected 1", msg_sev); end
        checks++; if (msg_id !== 2'd3) begin errors++; $display("FAIL tmo_id: got %0d expected 3", msg_id); end
        checks++; if (msg_time !== 32'd3) begin errors++; $display("FAIL tmo_time: got %0d expected 3", msg_time); end
        checks++; if (msg_data !== 32'h77) begin errors++; $display("FAIL tmo_data: got %0h expected 77", msg_data); end
      end
    end
    mon_ready = 1'b1;
    step();                           // edge 10: transfer
    mon_valid = 1'b0; mon_ready = 1'b0;
    checks++; if (warn_cnt !== 16'd1) begin errors++; $display("FAIL tmo_warn_cnt: got %0d expected 1", warn_cnt); end
    checks++; if (xfer_cnt !== 32'd1) begin errors++; $display("FAIL tmo_xfer_cnt: got %0d expected 1", xfer_cnt); end
    msg_ready = 1'b1;
    step();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL tmo_single_entry: got %b expected 0", msg_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h100 + 32'(n);
      step();
      mon_valid = 1'b0;
      step();                         // drop at edge 2n+1
    end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    checks++; if (err_cnt !== 16'd6) begin errors++; $display("FAIL ovf_err_cnt: got %0d expected 6", err_cnt); end
    msg_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid[%0d]: got %b expected 1", j, msg_valid); end
      checks++; if (msg_data !== 32'h100 + 32'(j)) begin errors++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", j, msg_data, 32'h100 + 32'(j)); end
      checks++; if (msg_time !== 32'(2*j+1)) begin errors++; $display("FAIL ovf_time[%0d]: got %0d expected %0d", j, msg_time, 2*j+1); end
      step();
    end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", msg_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_d [4];
    logic [31:0] exp_t [4];
    exp_d[0] = 32'h201; exp_t[0] = 32'd3;
    exp_d[1] = 32'h202; exp_t[1] = 32'd5;
    exp_d[2] = 32'h203; exp_t[2] = 32'd7;
    exp_d[3] = 32'h2FF; exp_t[3] = 32'd9;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h200 + 32'(n);
      step();
      mon_valid = 1'b0;
      step();
    end
    mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h2FF;
    step();                           // edge 8
    mon_valid = 1'b0;
    msg_ready = 1'b1;
    step();                           // edge 9: push while full, pop same edge
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL fpp_drop_cnt: got %0d expected 0", drop_cnt); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (msg_data !== exp_d[j]) begin errors++; $display("FAIL fpp_data[%0d]: got %0h expected %0h", j, msg_data, exp_d[j]); end
      checks++; if (msg_time !== exp_t[j]) begin errors++; $display("FAIL fpp_time[%0d]: got %0d expected %0d", j, msg_time, exp_t[j]); end
      step();
    end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained: got %b expected 0", msg_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h1;
    step(); step(); step();           // edges 0..2, stall_cnt 1..3
    mon_data = 32'h2;
    step();                           // edge 3: change and timeout together
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL b2b_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (warn_cnt !== 16'd1) begin errors++; $display("FAIL b2b_warn_cnt: got %0d expected 1", warn_cnt); end
    checks++; if (msg_id !== 2'd2) begin errors++; $display("FAIL b2b_prio_id: got %0d expected 2", msg_id); end
    checks++; if (msg_data !== 32'h2) begin errors++; $display("FAIL b2b_prio_data: got %0h expected 2", msg_data); end
    checks++; if (msg_time !== 32'd3) begin errors++; $display("FAIL b2b_prio_time: got %0d expected 3", msg_time); end
    mon_ready = 1'b1;
    step();                           // edge 4: transfer
    mon_ready = 1'b0; mon_data = 32'h3;
    step();                           // edge 5: stall
    mon_ready = 1'b1; mon_data = 32'h4;
    step();                           // edge 6: change with ready
    mon_valid = 1'b0; mon_ready = 1'b0;
    checks++; if (xfer_cnt !== 32'd2) begin errors++; $display("FAIL b2b_xfer_cnt: got %0d expected 2", xfer_cnt); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL b2b_err_cnt2: got %0d expected 2", err_cnt); end
    msg_ready = 1'b1;
    step();
    checks++; if (msg_id !== 2'd2) begin errors++; $display("FAIL b2b_second_id: got %0d expected 2", msg_id); end
    checks++; if (msg_data !== 32'h4) begin errors++; $display("FAIL b2b_second_data: got %0h expected 4", msg_data); end
    checks++; if (msg_time !== 32'd6) begin errors++; $display("FAIL b2b_second_time: got %0d expected 6", msg_time); end
    step();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", msg_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h300 + 32'(n);
      step();
      mon_valid = 1'b0;
      step();
    end
    mon_valid = 1'b1; mon_ready = 1'b0; mon_data = 32'h55;
    for (int e = 0; e < 5; e++) step();   // timeout at 4th stalled edge, then STALLED
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL rmid_pre_err_cnt: got %0d expected 2", err_cnt); end
    checks++; if (warn_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pre_warn_cnt: got %0d expected 1", warn_cnt); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL rmid_msg_valid: got %b expected 0", msg_valid); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rmid_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (warn_cnt !== 16'd0) begin errors++; $display("FAIL rmid_warn_cnt: got %0d expected 0", warn_cnt); end
    mon_valid = 1'b1; mon_ready = 1'b1; mon_data = 32'h5;
    step();
    mon_valid = 1'b0; mon_ready = 1'b0;
    checks++; if (xfer_cnt !== 32'd1) begin errors++; $display("FAIL rmid_xfer_cnt: got %0d expected 1", xfer_cnt); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_msg: got %b expected 0", msg_valid); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rmid_post_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  initial begin
    rst_n     = 1'b0;
    mon_valid = 1'b0;
    mon_ready = 1'b0;
    mon_data  = '0;
    msg_ready = 1'b0;
    test_reset();
    test_clean();
    test_valid_drop();
    test_data_unstable();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
